// File: rtl/memory_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter_pkg
// Description : Shared types and helpers for the three-port memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_arbiter_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Identity of the requester that owns (or wins) the memory port.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_INS  = 2'd1,
    SRC_DAT  = 2'd2,
    SRC_VGA  = 2'd3
  } arb_src_t;

  // Per-requester pulse vector, bit order {vga, dat, ins}.
  function automatic logic [2:0] src_onehot(input arb_src_t src);
    logic [2:0] vec;
    case (src)
      SRC_INS: vec = 3'b001;
      SRC_DAT: vec = 3'b010;
      SRC_VGA: vec = 3'b100;
      default: vec = 3'b000;
    endcase
    return vec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_priority_select.sv
`default_nettype none
// ============================================================================
// Module      : arb_priority_select
// Description : Combinational fixed-priority winner select (vga > dat > ins),
//               with an override that hands the port to instruction fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_priority_select
  import memory_arbiter_pkg::*;
(
  input  logic     ins_req,
  input  logic     dat_req,
  input  logic     vga_req,
  input  logic     force_ins,
  output arb_src_t winner
);

  // Forced instruction grant beats everyone; otherwise strict priority.
  always_comb begin
    winner = SRC_NONE;
    if (force_ins && ins_req) begin
      winner = SRC_INS;
    end else if (vga_req) begin
      winner = SRC_VGA;
    end else if (dat_req) begin
      winner = SRC_DAT;
    end else if (ins_req) begin
      winner = SRC_INS;
    end
  end

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Shares one memory port between instruction fetch, data
//               load/store and VGA pixel read. One transaction at a time:
//               IDLE -> ISSUE -> WAIT -> RESP. Optional instruction
//               anti-starvation guard enabled by macro ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ins_req,
  input  logic [ADDR_W-1:0] ins_addr,
  output logic              ins_gnt,
  output logic              ins_rvalid,
  output logic [DATA_W-1:0] ins_rdata,
  input  logic              dat_req,
  input  logic              dat_we,
  input  logic [ADDR_W-1:0] dat_addr,
  input  logic [DATA_W-1:0] dat_wdata,
  output logic              dat_gnt,
  output logic              dat_rvalid,
  output logic [DATA_W-1:0] dat_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // Parameter sanity: a zero latency or zero starve limit is meaningless.
  if (MEM_LATENCY < 1 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("memory_arbiter: MEM_LATENCY and STARVE_LIMIT must be >= 1");
  end

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  arb_state_t        state_q, state_d;
  arb_src_t          owner_q, owner_d;
  arb_src_t          winner;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              wr_q, wr_d;            // current transaction is a write
  logic [2:0]        gnt_q, gnt_d;          // {vga, dat, ins}
  logic [2:0]        rvalid_q, rvalid_d;    // {vga, dat, ins}
  logic [DATA_W-1:0] ins_rdata_q, ins_rdata_d;
  logic [DATA_W-1:0] dat_rdata_q, dat_rdata_d;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] resp_word;
  logic              force_ins;

  arb_priority_select u_select (
    .ins_req   (ins_req),
    .dat_req   (dat_req),
    .vga_req   (vga_req),
    .force_ins (force_ins),
    .winner    (winner)
  );

`ifdef ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q, starve_d;

  assign force_ins = (starve_q == STARVE_MAX);

  // Count arbitrations instruction fetch loses; clear once it is granted.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && winner != SRC_NONE) begin
      if (winner == SRC_INS) begin
        starve_d = '0;
      end else if (ins_req && !force_ins) begin
        starve_d = starve_q + STARVE_W'(1);
      end
    end
  end

  // Starve counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_ins = 1'b0;
`endif

  // Writes complete with a zero data word; reads return the memory word.
  assign resp_word = wr_q ? '0 : mem_rdata;

  // Next-state and next-output computation for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_d        = wr_q;
    mem_we_d    = 1'b0;
    gnt_d       = 3'b000;
    rvalid_d    = 3'b000;
    ins_rdata_d = ins_rdata_q;
    dat_rdata_d = dat_rdata_q;
    vga_rdata_d = vga_rdata_q;

    case (state_q)
      IDLE: begin
        if (winner != SRC_NONE) begin
          state_d = ISSUE;
          owner_d = winner;
          gnt_d   = src_onehot(winner);
          case (winner)
            SRC_VGA: begin
              mem_addr_d  = vga_addr;
              mem_wdata_d = '0;
              wr_d        = 1'b0;
            end
            SRC_DAT: begin
              mem_addr_d  = dat_addr;
              mem_wdata_d = dat_we ? dat_wdata : '0;
              wr_d        = dat_we;
              mem_we_d    = dat_we;
            end
            SRC_INS: begin
              mem_addr_d  = ins_addr;
              mem_wdata_d = '0;
              wr_d        = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d  = RESP;
          rvalid_d = src_onehot(owner_q);
          case (owner_q)
            SRC_INS: ins_rdata_d = resp_word;
            SRC_DAT: dat_rdata_d = resp_word;
            SRC_VGA: vga_rdata_d = resp_word;
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        owner_d = SRC_NONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Sequencer state and all registered outputs; reset drops any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= SRC_NONE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      wr_q        <= 1'b0;
      gnt_q       <= 3'b000;
      rvalid_q    <= 3'b000;
      ins_rdata_q <= '0;
      dat_rdata_q <= '0;
      vga_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      wr_q        <= wr_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      ins_rdata_q <= ins_rdata_d;
      dat_rdata_q <= dat_rdata_d;
      vga_rdata_q <= vga_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign ins_gnt    = gnt_q[0];
  assign dat_gnt    = gnt_q[1];
  assign vga_gnt    = gnt_q[2];
  assign ins_rvalid = rvalid_q[0];
  assign dat_rvalid = rvalid_q[1];
  assign vga_rvalid = rvalid_q[2];
  assign ins_rdata  = ins_rdata_q;
  assign dat_rdata  = dat_rdata_q;
  assign vga_rdata  = vga_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire
